// File: rtl/result_out_fifo_if.sv
// result_out_fifo_if: result/tag handshake bundle between producer, FIFO and consumer.
interface result_out_fifo_if #(parameter int DATA_W = 20, parameter int DEPTH = 4);
  logic in_valid, in_ready, in_tag, out_valid, out_ready, out_tag;
  logic [DATA_W-1:0] in_data, out_data;
  logic [$clog2(DEPTH):0] count;
  modport slave(input in_valid, in_data, in_tag, out_ready, output in_ready, out_valid, out_data, out_tag, count);
  modport master(output in_valid, in_data, in_tag, out_ready, input in_ready, out_valid, out_data, out_tag, count);
endinterface

// File: rtl/result_out_fifo.sv
// result_out_fifo: first-word-fall-through FIFO for tagged ALU/memory result words.
// Optional sticky overflow flag with clear input when RESULT_OUT_FIFO_OVF_EN is defined.
module result_out_fifo #(
  parameter int DATA_W = 20,
  parameter int ALU_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef RESULT_OUT_FIFO_OVF_EN
  input  logic clr_ovf,
  output logic ovf_flag,
`endif
  result_out_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] ALU_MASK = {{(DATA_W-ALU_W){1'b0}}, {ALU_W{1'b1}}};
  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic push, pop;
  logic [DATA_W-1:0] wdata;
  assign bus.in_ready = cnt != (AW+1)'(DEPTH);
  assign bus.out_valid = cnt != '0;
  assign bus.count = cnt;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  assign wdata = bus.in_tag ? bus.in_data & ALU_MASK : bus.in_data;
  // Empty FIFO presents zeros rather than stale storage contents.
  assign {bus.out_tag, bus.out_data} = bus.out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.in_tag, wdata};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
`ifdef RESULT_OUT_FIFO_OVF_EN
  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_flag <= 1'b0;
    else if (bus.in_valid && !bus.in_ready) ovf_flag <= 1'b1;
    else if (clr_ovf) ovf_flag <= 1'b0;
`endif
endmodule

// File: tb/tb_result_out_fifo.sv
// tb_result_out_fifo: scoreboard bench for result_out_fifo (overflow flag tests under RESULT_OUT_FIFO_OVF_EN).
module tb_result_out_fifo;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  logic [20:0] q[$];
  result_out_fifo_if #(.DATA_W(20), .DEPTH(DEPTH)) bus();
`ifdef RESULT_OUT_FIFO_OVF_EN
  logic clr_ovf = 1'b0;
  logic ovf_flag;
  result_out_fifo dut (.clk(clk), .rst_n(rst_n), .clr_ovf(clr_ovf), .ovf_flag(ovf_flag), .bus(bus));
`else
  result_out_fifo dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [19:0] d, input logic t, input logic r);
    logic [20:0] head;
    logic [25:0] obs, exp_v;
    logic do_push, do_pop;
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_tag = t;
    bus.out_ready = r;
    #1;
    head = q.size() != 0 ? q[0] : 21'h0;
    obs = {bus.in_ready, bus.out_valid, bus.count, bus.out_tag, bus.out_data};
    exp_v = {q.size() != DEPTH, q.size() != 0, 3'(q.size()), head};
    total++;
    if (obs !== exp_v) $display("FAIL step: got rdy/vld/cnt/tag/data=%h required %h", obs, exp_v);
    else passed++;
    do_push = v && q.size() != DEPTH;
    do_pop = r && q.size() != 0;
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back({t, t ? {4'h0, d[15:0]} : d});
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) step(1'b0, 20'h0, 1'b0, 1'b1);
    step(1'b0, 20'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    total++;
    if ({bus.count, bus.out_valid, bus.in_ready, bus.out_tag, bus.out_data} !== {3'd0, 1'b0, 1'b1, 1'b0, 20'h0})
      $display("FAIL reset: got cnt=%0d vld=%b rdy=%b tag=%b data=%h required 0 0 1 0 0",
               bus.count, bus.out_valid, bus.in_ready, bus.out_tag, bus.out_data);
    else passed++;
  endtask

  task automatic test_single();
    step(1'b1, 20'hABCDE, 1'b0, 1'b0);
    step(1'b0, 20'h0, 1'b0, 1'b0);
    total++;
    if ({bus.out_valid, bus.out_tag, bus.out_data, bus.count} !== {1'b1, 1'b0, 20'hABCDE, 3'd1})
      $display("FAIL single: got vld=%b tag=%b data=%h cnt=%0d required 1 0 abcde 1",
               bus.out_valid, bus.out_tag, bus.out_data, bus.count);
    else passed++;
    step(1'b0, 20'h0, 1'b0, 1'b1);
    total++;
    if ({bus.count, bus.out_data} !== {3'd0, 20'h0})
      $display("FAIL single_pop: got cnt=%0d data=%h required 0 00000", bus.count, bus.out_data);
    else passed++;
  endtask

  task automatic test_tag();
    step(1'b1, 20'hF1234, 1'b1, 1'b0);
    total++;
    if ({bus.out_tag, bus.out_data} !== {1'b1, 20'h01234})
      $display("FAIL tag_mask: got tag=%b data=%h required 1 01234", bus.out_tag, bus.out_data);
    else passed++;
    drain();
  endtask

  task automatic test_full();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 20'(i), 1'b0, 1'b0);
    step(1'b1, 20'h00005, 1'b0, 1'b0);
    total++;
    if ({bus.count, bus.in_ready} !== {3'd4, 1'b0})
      $display("FAIL full: got cnt=%0d rdy=%b required 4 0", bus.count, bus.in_ready);
    else passed++;
    for (int i = 1; i <= DEPTH; i++) begin
      total++;
      if (bus.out_data !== 20'(i)) $display("FAIL drain_order: got %h required %h", bus.out_data, 20'(i));
      else passed++;
      step(1'b0, 20'h0, 1'b0, 1'b1);
    end
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL drain_empty: got vld=%b required 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    step(1'b1, 20'h10000, 1'b0, 1'b0);
    step(1'b1, 20'h10001, 1'b1, 1'b0);
    for (int i = 2; i < 12; i++) step(1'b1, 20'h10000 + 20'(i), 1'(i % 2), 1'b1);
    total++;
    if (bus.count !== 3'd2) $display("FAIL b2b_count: got %0d required 2", bus.count);
    else passed++;
    drain();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 20'h20000 + 20'(i), 1'b0, 1'b0);
    step(1'b1, 20'h2AAAA, 1'b0, 1'b1);
    total++;
    if ({bus.count, bus.in_ready} !== {3'd3, 1'b1})
      $display("FAIL full_pop: got cnt=%0d rdy=%b required 3 1", bus.count, bus.in_ready);
    else passed++;
    step(1'b1, 20'h2AAAA, 1'b0, 1'b0);
    total++;
    if (bus.count !== 3'd4) $display("FAIL held_word: got cnt=%0d required 4", bus.count);
    else passed++;
    drain();
  endtask

`ifdef RESULT_OUT_FIFO_OVF_EN
  task automatic test_ovf();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 20'h30000 + 20'(i), 1'b0, 1'b0);
    step(1'b1, 20'h3FFFF, 1'b0, 1'b0);
    step(1'b0, 20'h0, 1'b0, 1'b0);
    total++;
    if (ovf_flag !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", ovf_flag);
    else passed++;
    clr_ovf = 1'b1;
    step(1'b0, 20'h0, 1'b0, 1'b0);
    clr_ovf = 1'b0;
    total++;
    if (ovf_flag !== 1'b0) $display("FAIL ovf_clear: got %b required 0", ovf_flag);
    else passed++;
    clr_ovf = 1'b1;
    step(1'b1, 20'h3FFFF, 1'b0, 1'b0);
    clr_ovf = 1'b0;
    total++;
    if (ovf_flag !== 1'b1) $display("FAIL ovf_set_wins: got %b required 1", ovf_flag);
    else passed++;
    drain();
  endtask
`endif

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 20'h40000 + 20'(i), 1'b0, 1'b0);
    step(1'b0, 20'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.count, bus.out_valid, bus.in_ready, bus.out_data} !== {3'd0, 1'b0, 1'b1, 20'h0})
      $display("FAIL async_reset: got cnt=%0d vld=%b rdy=%b data=%h required 0 0 1 0",
               bus.count, bus.out_valid, bus.in_ready, bus.out_data);
    else passed++;
`ifdef RESULT_OUT_FIFO_OVF_EN
    total++;
    if (ovf_flag !== 1'b0) $display("FAIL ovf_reset: got %b required 0", ovf_flag);
    else passed++;
`endif
    q.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 20'h55555, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_tag = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_single();
    test_tag();
    test_full();
    test_back_to_back();
    test_full_pop();
`ifdef RESULT_OUT_FIFO_OVF_EN
    test_ovf();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
